// File: rtl/counter_pkg.sv
// Shared definitions for the counter measurement sequencer: op codes,
// sequencer states, status byte layout and result stream length.
package counter_pkg;

    typedef enum logic [1:0] {
        OP_FREQ = 2'd0,
        OP_TIME = 2'd1,
        OP_ZS   = 2'd2,
        OP_FS   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_GATE    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_SEND    = 3'd5
    } state_e;

    localparam int STAT_TIMEOUT = 0;
    localparam int STAT_OP_LO   = 1;
    localparam int STAT_STRT    = 3;
    localparam int STAT_STOP    = 4;

    localparam int RES_BYTES = 11;

    function automatic logic [7:0] status_byte(input logic timed_out,
                                               input op_e  op,
                                               input logic strt_seen,
                                               input logic stop_seen);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_TIMEOUT]     = timed_out;
        s[STAT_OP_LO +: 2]  = op;
        s[STAT_STRT]        = strt_seen;
        s[STAT_STOP]        = stop_seen;
        return s;
    endfunction

endpackage

// File: rtl/counter_seq_ack_sync.sv
// Two-flop synchronizer for an asynchronous vernier acknowledge, followed
// by a sticky "seen" flag that holds until the sequencer clears it.
module ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic ack,
    input  logic clr,
    output logic seen
);

    logic meta;
    logic sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            seen <= 1'b0;
        end else begin
            meta <= ack;
            sync <= meta;
            seen <= clr ? 1'b0 : (seen | sync);
        end
    end

endmodule

// File: rtl/counter_seq.sv
// Host-side measurement sequencer: runs one counter measurement per command
// and returns the captured results as an 11-byte valid/ready stream.
module counter_seq
    import counter_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096,
    parameter int GATE_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [GATE_W-1:0] cmd_gate,
    input  logic [1:0]        cmd_cnt_mode,
    input  logic              cmd_tmr_mode,
    output logic              cnt_rst,
    output logic              strt,
    output logic              stop,
    output logic [1:0]        strt_mode,
    output logic [1:0]        stop_mode,
    output logic [1:0]        cnt_mode,
    output logic              tmr_mode,
    output logic              clb_zs,
    output logic              clb_fs,
    input  logic              strt_ack,
    input  logic              stop_ack,
    input  logic [7:0]        strt_dout,
    input  logic [7:0]        stop_dout,
    input  logic [31:0]       cnt_dout,
    input  logic [31:0]       tmr_dout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
    localparam int SH_W = RES_BYTES * 8;

    state_e            state;
    op_e               op;
    logic [GATE_W-1:0] gate_len;
    logic [GATE_W-1:0] gate_cnt;
    logic [15:0]       settle_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              timed_out;
    logic [SH_W-1:0]   res_sh;
    logic [3:0]        byte_cnt;
    logic              strt_seen;
    logic              stop_seen;
    logic              flags_clr;

    assign cmd_ready = (state == ST_IDLE);
    assign res_data  = res_sh[SH_W-1 -: 8];
    assign flags_clr = (state == ST_IDLE);

    ack_sync u_strt_sync (
        .clk  (clk),
        .rst  (rst),
        .ack  (strt_ack),
        .clr  (flags_clr),
        .seen (strt_seen)
    );

    ack_sync u_stop_sync (
        .clk  (clk),
        .rst  (rst),
        .ack  (stop_ack),
        .clr  (flags_clr),
        .seen (stop_seen)
    );

    // Single sequencer FSM; every counter-facing output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op         <= OP_FREQ;
            gate_len   <= '0;
            gate_cnt   <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            timed_out  <= 1'b0;
            res_sh     <= '0;
            byte_cnt   <= '0;
            cnt_rst    <= 1'b1;
            strt       <= 1'b0;
            stop       <= 1'b0;
            strt_mode  <= 2'd0;
            stop_mode  <= 2'd0;
            cnt_mode   <= 2'd0;
            tmr_mode   <= 1'b0;
            clb_zs     <= 1'b0;
            clb_fs     <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_rst <= 1'b1;
                    if (cmd_valid) begin
                        op         <= op_e'(cmd_op);
                        gate_len   <= (cmd_gate == '0) ? GATE_W'(1) : cmd_gate;
                        cnt_mode   <= cmd_cnt_mode;
                        tmr_mode   <= cmd_tmr_mode;
                        strt_mode  <= 2'd0;
                        stop_mode  <= (cmd_op == 2'(OP_TIME)) ? 2'd1 : 2'd0;
                        settle_cnt <= '0;
                        timed_out  <= 1'b0;
                        cnt_rst    <= 1'b0;
                        state      <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        gate_cnt <= gate_len;
                        tmo_cnt  <= '0;
                        // TIME opens and closes the interval itself, so it skips the gate.
                        case (op)
                            OP_FREQ: begin
                                strt  <= 1'b1;
                                state <= ST_GATE;
                            end
                            OP_TIME: begin
                                strt  <= 1'b1;
                                stop  <= 1'b1;
                                state <= ST_STOP;
                            end
                            OP_ZS: begin
                                clb_zs <= 1'b1;
                                state  <= ST_GATE;
                            end
                            default: begin
                                clb_fs <= 1'b1;
                                state  <= ST_GATE;
                            end
                        endcase
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end

                ST_GATE: begin
                    if (gate_cnt == GATE_W'(1)) begin
                        strt  <= 1'b0;
                        stop  <= (op == OP_FREQ);
                        state <= ST_STOP;
                    end else begin
                        gate_cnt <= gate_cnt - 1'b1;
                    end
                end

                ST_STOP: begin
                    if (strt_seen && stop_seen) begin
                        strt   <= 1'b0;
                        stop   <= 1'b0;
                        clb_zs <= 1'b0;
                        clb_fs <= 1'b0;
                        state  <= ST_CAPTURE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timed_out <= 1'b1;
                        strt      <= 1'b0;
                        stop      <= 1'b0;
                        clb_zs    <= 1'b0;
                        clb_fs    <= 1'b0;
                        state     <= ST_CAPTURE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    res_sh    <= {status_byte(timed_out, op, strt_seen, stop_seen),
                                  cnt_dout, tmr_dout, strt_dout, stop_dout};
                    byte_cnt  <= '0;
                    res_valid <= 1'b1;
                    state     <= ST_SEND;
                end

                ST_SEND: begin
                    // The stream only advances on a handshake, so res_data holds when stalled.
                    if (res_ready) begin
                        if (byte_cnt == 4'(RES_BYTES - 1)) begin
                            res_valid <= 1'b0;
                            cnt_rst   <= 1'b1;
                            strt_mode <= 2'd0;
                            stop_mode <= 2'd0;
                            cnt_mode  <= 2'd0;
                            tmr_mode  <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            res_sh   <= {res_sh[SH_W-9:0], 8'h00};
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq.sv
// Scoreboard bench for counter_seq: commands push the expected byte stream,
// a separate monitor pops and compares every transferred result byte.
module tb_counter_seq;

    localparam int TB_SETTLE  = 4;
    localparam int TB_TIMEOUT = 64;
    localparam int TB_GATE_W  = 24;

    localparam logic [1:0] OPC_FREQ = 2'd0;
    localparam logic [1:0] OPC_TIME = 2'd1;
    localparam logic [1:0] OPC_ZS   = 2'd2;
    localparam logic [1:0] OPC_FS   = 2'd3;

    logic                 clk;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [TB_GATE_W-1:0] cmd_gate;
    logic [1:0]           cmd_cnt_mode;
    logic                 cmd_tmr_mode;
    logic                 cnt_rst;
    logic                 strt;
    logic                 stop;
    logic [1:0]           strt_mode;
    logic [1:0]           stop_mode;
    logic [1:0]           cnt_mode;
    logic                 tmr_mode;
    logic                 clb_zs;
    logic                 clb_fs;
    logic                 strt_ack;
    logic                 stop_ack;
    logic [7:0]           strt_dout;
    logic [7:0]           stop_dout;
    logic [31:0]          cnt_dout;
    logic [31:0]          tmr_dout;
    logic                 res_valid;
    logic                 res_ready;
    logic [7:0]           res_data;

    int checks   = 0;
    int failures = 0;
    int ready_mode = 0;
    logic [7:0] exp_q[$];

    counter_seq #(
        .SETTLE  (TB_SETTLE),
        .TIMEOUT (TB_TIMEOUT),
        .GATE_W  (TB_GATE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_gate     (cmd_gate),
        .cmd_cnt_mode (cmd_cnt_mode),
        .cmd_tmr_mode (cmd_tmr_mode),
        .cnt_rst      (cnt_rst),
        .strt         (strt),
        .stop         (stop),
        .strt_mode    (strt_mode),
        .stop_mode    (stop_mode),
        .cnt_mode     (cnt_mode),
        .tmr_mode     (tmr_mode),
        .clb_zs       (clb_zs),
        .clb_fs       (clb_fs),
        .strt_ack     (strt_ack),
        .stop_ack     (stop_ack),
        .strt_dout    (strt_dout),
        .stop_dout    (stop_dout),
        .cnt_dout     (cnt_dout),
        .tmr_dout     (tmr_dout),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: the stream is the status byte followed by the dout buses, MSB first.
    task automatic pushExpected(input logic [1:0] op, input bit give_s, input bit give_p);
        logic [7:0] status;
        status = {3'b000, give_p, give_s, op, ~(give_s & give_p)};
        exp_q.push_back(status);
        for (int i = 3; i >= 0; i--) exp_q.push_back(cnt_dout[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(tmr_dout[i*8 +: 8]);
        exp_q.push_back(strt_dout);
        exp_q.push_back(stop_dout);
    endtask

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ~res_ready;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a byte transfers at the next posedge whenever valid and ready are both seen here.
    initial begin
        logic       hold_pending;
        logic [7:0] hold_val;
        logic [7:0] e;
        hold_pending = 1'b0;
        hold_val     = 8'h00;
        forever begin
            @(negedge clk);
            if (hold_pending) begin
                checkOutput("res_data_hold", {res_valid, res_data}, {1'b1, hold_val});
                hold_pending = 1'b0;
            end
            if (res_valid === 1'b1) begin
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_byte", {24'h0, res_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("res_byte", res_data, e);
                    end
                end else begin
                    hold_pending = 1'b1;
                    hold_val     = res_data;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [TB_GATE_W-1:0] gate,
                                 input logic [1:0] cm, input logic tm,
                                 input bit give_s, input bit give_p, input int ack_dly,
                                 input int rmode, input bit mid_cmd, input bit do_reset);
        int   n;
        int   c;
        int   strt_len;
        int   stop_c;
        int   rv_c;
        int   ack_c;
        int   clb_cnt;
        int   gate_eff;
        bit   clb_done;
        bit   calib_bad;
        bit   mode_bad;
        bit   idle_bad;
        logic clb_line;
        logic [1:0] exp_sm;
        logic [3:0] exp_lines;

        gate_eff  = (gate == 0) ? 1 : int'(gate);
        exp_sm    = (op == OPC_TIME) ? 2'd1 : 2'd0;
        case (op)
            OPC_FREQ: exp_lines = 4'b1000;
            OPC_TIME: exp_lines = 4'b1100;
            OPC_ZS:   exp_lines = 4'b0010;
            default:  exp_lines = 4'b0001;
        endcase
        ready_mode = rmode;

        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_wait", cmd_ready, 1);
            return;
        end

        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_gate     = gate;
        cmd_cnt_mode = cm;
        cmd_tmr_mode = tm;
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        cmd_op       = 2'($urandom);
        cmd_gate     = TB_GATE_W'($urandom);
        cmd_cnt_mode = 2'($urandom);
        cmd_tmr_mode = 1'($urandom);
        pushExpected(op, give_s, give_p);

        @(negedge clk);
        checkOutput("accept_cnt_rst_ready", {cnt_rst, cmd_ready}, 2'b00);

        n = 0;
        while (!(strt | stop | clb_zs | clb_fs) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("settle_cycles", n, TB_SETTLE);
        checkOutput("gate_start_lines", {strt, stop, clb_zs, clb_fs}, exp_lines);

        if (do_reset) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            checkOutput("reset_abort",
                        {cnt_rst, strt, stop, clb_zs, clb_fs, cmd_ready, res_valid},
                        7'b1000010);
            exp_q.delete();
            return;
        end

        c = 1; strt_len = 0; stop_c = -1; rv_c = -1; ack_c = -1;
        clb_cnt = 0; clb_done = 0; calib_bad = 0; mode_bad = 0;
        while (c <= 1000) begin
            if (res_valid) begin
                rv_c = c;
                break;
            end
            if (op == OPC_FREQ && strt) strt_len++;
            if ((op == OPC_FREQ || op == OPC_TIME) && stop && stop_c < 0) begin
                stop_c = c;
                if (op == OPC_FREQ) checkOutput("freq_strt_low_at_stop", strt, 0);
            end
            if (op == OPC_ZS || op == OPC_FS) begin
                clb_line = (op == OPC_ZS) ? clb_zs : clb_fs;
                if (strt || stop || ((op == OPC_ZS) ? clb_fs : clb_zs)) calib_bad = 1;
                if (!clb_done) begin
                    if (clb_line) clb_cnt++;
                    else clb_done = 1;
                end
            end
            if ({strt_mode, stop_mode, cnt_mode, tmr_mode} !== {2'b00, exp_sm, cm, tm})
                mode_bad = 1;
            if (c == ack_dly) begin
                #2;
                strt_ack = give_s;
                stop_ack = give_p;
                ack_c    = c;
            end
            @(negedge clk);
            c++;
        end
        #2;
        strt_ack = 1'b0;
        stop_ack = 1'b0;
        if (rv_c < 0) begin
            checkOutput("res_valid_wait", res_valid, 1);
            exp_q.delete();
            return;
        end

        checkOutput("modes_stable", mode_bad, 0);
        if (op == OPC_FREQ) begin
            checkOutput("freq_strt_len", strt_len, gate_eff);
            checkOutput("freq_stop_delay", stop_c, gate_eff + 1);
        end
        if (op == OPC_ZS || op == OPC_FS) begin
            checkOutput("calib_other_lines", calib_bad, 0);
            checkOutput("calib_line_len", clb_cnt, rv_c - 2);
        end
        if (give_s && give_p)
            checkOutput("ack_to_valid_min", (rv_c - ack_c) >= 4, 1);
        else if (op == OPC_FREQ || op == OPC_TIME)
            checkOutput("timeout_to_valid", rv_c - stop_c, TB_TIMEOUT + 1);

        n = 0;
        while (!cmd_ready && n < 500) begin
            if (mid_cmd) begin
                cmd_valid = (n >= 2 && n < 5);
                cmd_op    = OPC_FREQ;
            end
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        if (rmode == 0) checkOutput("stream_cycles", n, 11);
        checkOutput("queue_drained", exp_q.size(), 0);

        if (mid_cmd) begin
            idle_bad = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (!cnt_rst || res_valid || !cmd_ready) idle_bad = 1;
            end
            checkOutput("busy_cmd_ignored", idle_bad, 0);
        end
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [23:0] r_gate;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_gate = '0;
        cmd_cnt_mode = 2'd0; cmd_tmr_mode = 1'b0; strt_ack = 1'b0; stop_ack = 1'b0;
        strt_dout = 8'h00; stop_dout = 8'h00; cnt_dout = 32'h0; tmr_dout = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_ctrl", {cmd_ready, cnt_rst, strt, stop, clb_zs, clb_fs, res_valid},
                    7'b1100000);
        checkOutput("reset_modes", {strt_mode, stop_mode, cnt_mode, tmr_mode}, 7'b0);

        cnt_dout = 32'h01020304; tmr_dout = 32'h05060708; strt_dout = 8'h09; stop_dout = 8'h0A;
        applyStimulus(OPC_FREQ, 24'd100, 2'd2, 1'b1, 1, 1, 121, 0, 0, 0);

        cnt_dout = 32'hA1B2C3D4; tmr_dout = 32'h11223344; strt_dout = 8'h5A; stop_dout = 8'hA5;
        applyStimulus(OPC_TIME, 24'd7, 2'd1, 1'b0, 1, 1, 6, 0, 0, 0);

        cnt_dout = 32'hDEADBEEF; tmr_dout = 32'h00C0FFEE; strt_dout = 8'h33; stop_dout = 8'h44;
        applyStimulus(OPC_ZS, 24'd12, 2'd0, 1'b1, 1, 1, 5, 0, 0, 0);
        cnt_dout = 32'h12345678; tmr_dout = 32'h9ABCDEF0; strt_dout = 8'h77; stop_dout = 8'h88;
        applyStimulus(OPC_FS, 24'd3, 2'd3, 1'b0, 1, 1, 9, 0, 0, 0);

        cnt_dout = 32'hCAFEF00D; tmr_dout = 32'h0BADF00D; strt_dout = 8'h01; stop_dout = 8'h02;
        applyStimulus(OPC_FREQ, 24'd10, 2'd1, 1'b0, 1, 0, 4, 0, 0, 0);

        cnt_dout = 32'h55AA55AA; tmr_dout = 32'hF0E1D2C3; strt_dout = 8'hB4; stop_dout = 8'hA5;
        applyStimulus(OPC_FREQ, 24'd5, 2'd0, 1'b0, 1, 1, 8, 1, 1, 0);

        applyStimulus(OPC_FREQ, 24'd50, 2'd0, 1'b0, 1, 1, 60, 0, 0, 1);
        cnt_dout = 32'h0000FFFF; tmr_dout = 32'hFFFF0000; strt_dout = 8'hFE; stop_dout = 8'hEF;
        applyStimulus(OPC_FREQ, 24'd0, 2'd2, 1'b1, 1, 1, 3, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            r_op      = 2'($urandom_range(0, 3));
            r_gate    = 24'($urandom_range(0, 20));
            cnt_dout  = $urandom;
            tmr_dout  = $urandom;
            strt_dout = 8'($urandom);
            stop_dout = 8'($urandom);
            applyStimulus(r_op, r_gate, 2'($urandom), 1'($urandom),
                          $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                          $urandom_range(1, 30), $urandom_range(0, 2), 0, 0);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
